// File: rtl/axil_master_bridge.sv
// AXI4-lite initiator: single outstanding command, every AXI output registered.
// Optional watchdog compiled in with AXIL_MST_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module axil_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic                RVALID,
  output logic                RREADY
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RSP
  } state_t;

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                expire;
  logic                abort;

`ifdef AXIL_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy;

  assign busy   = state_q inside {WR_REQ, WR_RESP, RD_ADDR, RD_DATA};
  assign expire = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Restart on every state change so each phase gets its own budget.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (busy)          cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    abort       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rsp_write_d = cmd_write;
          if (cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr;
          end
        end
      end
      WR_REQ: begin
        if (awvalid_q && AWREADY) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && WREADY) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) state_d = WR_RESP;
        else if (expire)           abort   = 1'b1;
      end
      WR_RESP: begin
        bready_d = 1'b1;
        if (BVALID && bready_q) begin
          bready_d    = 1'b0;
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RD_ADDR: begin
        if (arvalid_q && ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RD_DATA: begin
        rready_d = 1'b1;
        if (RVALID && rready_q) begin
          rready_d    = 1'b0;
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = RDATA;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RSP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      state_d     = RSP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
    end
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign AWVALID   = awvalid_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;
  assign AWADDR    = awaddr_q;
  assign ARADDR    = araddr_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_axil_master_bridge.sv
// Bench for axil_master_bridge: memory-backed AXI4-lite responder with
// random wait states, plus a command-level memory model for expected data.
module tb_axil_master_bridge;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;

  axil_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  // Responder memory and command-level model memory, kept separately.
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];

  function automatic logic [31:0] bget(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : mem_init(a);
  endfunction
  function automatic logic [31:0] mget(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : mem_init(a);
  endfunction

  // Responder knobs.
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  bit spur = 0;

  logic        p_awv, p_wv, p_br, p_arv, p_rr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;
  int          aw_c, w_c, ar_c, b_c, r_c;
  bit          aw_got, w_got, ar_got, b_pend, b_on, r_on;
  logic [31:0] got_awaddr, got_wdata, got_araddr;
  logic [3:0]  got_wstrb;
  int          n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0;

  task automatic bfm_clear();
    AWREADY = 0; WREADY = 0; ARREADY = 0;
    BVALID = 0; RVALID = 0; RDATA = 0;
    aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    b_pend = 0; b_on = 0; r_on = 0;
    p_awv = 0; p_wv = 0; p_br = 0; p_arv = 0; p_rr = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
  endtask

  initial bfm_clear();

  always begin
    @(posedge ACLK); #1;
    if (ARESET) begin
      bfm_clear();
    end else begin
      if (p_awv && AWREADY) begin
        aw_got = 1; got_awaddr = p_awaddr; n_aw++;
      end else if (p_awv) begin
        chk("aw_hold", {AWVALID, AWADDR}, {1'b1, p_awaddr});
      end
      if (p_wv && WREADY) begin
        w_got = 1; got_wdata = p_wdata; got_wstrb = p_wstrb; n_w++;
      end else if (p_wv) begin
        chk("w_hold", {WVALID, WSTRB, WDATA}, {1'b1, p_wstrb, p_wdata});
      end
      if (p_arv && ARREADY) begin
        ar_got = 1; got_araddr = p_araddr; n_ar++;
      end else if (p_arv) begin
        chk("ar_hold", {ARVALID, ARADDR}, {1'b1, p_araddr});
      end
      if (BVALID && p_br) begin
        n_b++; aw_got = 0; w_got = 0; b_pend = 0; b_on = 0;
        BVALID = 0; b_c = 0;
      end
      if (RVALID && p_rr) begin
        n_r++; ar_got = 0; r_on = 0; RVALID = 0; r_c = 0;
      end
      if (aw_got && w_got && !b_pend) begin
        bmem[got_awaddr] = merge(bget(got_awaddr), got_wdata, got_wstrb);
        b_pend = 1; b_c = 0;
      end
      if (BREADY) chk("bready_early", {aw_got, w_got}, 2'b11);
      if (RREADY) chk("rready_early", ar_got, 1);
      AWREADY = AWVALID && (aw_c >= aw_dly);
      aw_c    = AWVALID ? aw_c + 1 : 0;
      WREADY  = WVALID && (w_c >= w_dly);
      w_c     = WVALID ? w_c + 1 : 0;
      ARREADY = ARVALID && (ar_c >= ar_dly);
      ar_c    = ARVALID ? ar_c + 1 : 0;
      if (b_pend) begin
        if (!b_on) begin
          BVALID = 0;
          if (b_c >= b_dly) begin BVALID = 1; b_on = 1; end
          else b_c++;
        end
      end else begin
        BVALID = spur && ($urandom_range(0, 1) == 1);
      end
      if (ar_got) begin
        if (!r_on) begin
          RVALID = 0;
          if (r_c >= r_dly) begin
            RVALID = 1; r_on = 1; RDATA = bget(got_araddr);
          end else r_c++;
        end
      end else begin
        RVALID = spur && ($urandom_range(0, 1) == 1);
        RDATA  = $urandom;
      end
      p_awv = AWVALID; p_wv = WVALID; p_br = BREADY;
      p_arv = ARVALID; p_rr = RREADY;
      p_awaddr = AWADDR; p_wdata = WDATA; p_wstrb = WSTRB;
      p_araddr = ARADDR;
    end
  end

  task automatic step();
    @(posedge ACLK); #2;
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input int hold, input int exp_lat,
                         input bit exp_err);
    int k, acc, naw0, nw0, nar0, nb0, nr0;
    logic [33:0] snap;
    logic [31:0] exp_rd;
    k = 0;
    while (!cmd_ready && k < 50) begin step(); k++; end
    if (!cmd_ready) begin chk("cmd_ready_wait", 0, 1); return; end
    naw0 = n_aw; nw0 = n_w; nar0 = n_ar; nb0 = n_b; nr0 = n_r;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a;
    cmd_wdata = d; cmd_wstrb = s;
    step();
    acc = cyc;
    cmd_valid = $urandom_range(0, 1);
    cmd_write = $urandom_range(0, 1);
    cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
    chk("cmd_ready_drop", cmd_ready, 0);
    k = 0;
    while (!rsp_valid && k < 300) begin step(); k++; end
    cmd_valid = 0;
    if (!rsp_valid) begin chk("rsp_wait", 0, 1); return; end
    if (exp_lat > 0) chk("latency", cyc - acc + 1, exp_lat);
    snap = {rsp_write, rsp_err, rsp_rdata};
    for (int i = 0; i < hold; i++) begin
      step();
      chk("rsp_stable", {rsp_valid, rsp_write, rsp_err, rsp_rdata},
          {1'b1, snap});
      chk("cmd_ready_busy", cmd_ready, 0);
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    exp_rd = (wr || exp_err) ? 32'h0 : mget(a);
    chk("rsp_write", snap[33], wr);
    chk("rsp_err", snap[32], exp_err);
    chk("rsp_rdata", snap[31:0], exp_rd);
    if (wr && !exp_err) begin
      mmem[a] = merge(mget(a), d, s);
      chk("aw_count", n_aw - naw0, 1);
      chk("awaddr", got_awaddr, a);
      chk("w_count", n_w - nw0, 1);
      chk("wdata", got_wdata, d);
      chk("wstrb", got_wstrb, s);
      chk("b_count", n_b - nb0, 1);
    end else if (!wr) begin
      chk("ar_count", n_ar - nar0, exp_err ? 0 : 1);
      chk("r_count", n_r - nr0, exp_err ? 0 : 1);
      if (!exp_err) chk("araddr", got_araddr, a);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit seen;
    ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
    cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    bmem[32'h20] = 32'h1234_5678;
    mmem[32'h20] = 32'h1234_5678;
    #1;
    chk("rst_ctl", {AWVALID, WVALID, BREADY, ARVALID, RREADY,
                    cmd_ready, rsp_valid, rsp_write, rsp_err}, 0);
    chk("rst_data", {AWADDR, ARADDR}, 0);
    repeat (3) @(posedge ACLK);
    #2 ARESET = 0;
    step();
    chk("cmd_ready_idle", cmd_ready, 1);

    // Zero-wait write and read.
    run_cmd(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 4, 0);
    run_cmd(0, 32'h10, 0, 0, 0, 4, 0);
    // AW accepted early, W late.
    aw_dly = 0; w_dly = 3;
    run_cmd(1, 32'h14, 32'hA5A5_0F0F, 4'h5, 0, 7, 0);
    w_dly = 0;
    // Delayed AR and R with spurious B traffic.
    ar_dly = 2; r_dly = 3; spur = 1;
    run_cmd(0, 32'h20, 0, 0, 0, 8, 0);
    ar_dly = 0; r_dly = 0; spur = 0;
    // Response back-pressure.
    run_cmd(0, 32'h14, 0, 0, 5, 4, 0);
    run_cmd(1, 32'h20, 32'h0BAD_F00D, 4'h6, 5, 4, 0);

    // Reset in the middle of a write with W stalled.
    w_dly = 60;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h18;
    cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
    step();
    cmd_valid = 0;
    repeat (3) step();
    chk("w_pending", WVALID, 1);
    #3 ARESET = 1;
    #1;
    chk("arst_ctl", {AWVALID, WVALID, BREADY, ARVALID, RREADY,
                     cmd_ready, rsp_valid, rsp_write, rsp_err}, 0);
    chk("arst_data", {AWADDR, ARADDR, WDATA, rsp_rdata}, 0);
    chk("arst_strb", WSTRB, 0);
    repeat (2) @(posedge ACLK);
    #2 ARESET = 0;
    w_dly = 0;
    seen = 0;
    repeat (8) begin step(); seen |= rsp_valid; end
    chk("no_rsp_after_rst", seen, 0);
    run_cmd(0, 32'h18, 0, 0, 0, 4, 0);

    // Randomised traffic.
    spur = 1;
    for (int n = 0; n < 40; n++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      r_dly = $urandom_range(0, 3);
      run_cmd($urandom_range(0, 1), 32'($urandom_range(0, 7)) << 2,
              $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 2), 0, 0);
    end
    spur = 0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;

`ifdef AXIL_MST_TIMEOUT_EN
    ar_dly = 1000;
    run_cmd(0, 32'h30, 0, 0, 1, 17, 1);
    ar_dly = 0;
    w_dly = 1000;
    run_cmd(1, 32'h34, 32'h1111_2222, 4'hF, 0, 0, 1);
    w_dly = 0;
    run_cmd(0, 32'h30, 0, 0, 0, 4, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axil_master_bridge.md
Name: axil_master_bridge

Overview:
- AXI4-lite initiator that converts a single-outstanding command/response interface into AXI4-lite write and read transactions.
- Drives the same channel set as the existing AXI4-lite slave DUT: AW, W, B, AR, R. No BRESP, RRESP or PROT signals.
- Sits between local control logic, or a bench sequencer, and any AXI4-lite responder.
- One transaction in flight at a time. Every AXI output is registered.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width; WSTRB width = DATA_W/8
TIMEOUT_CYCLES, 256, watchdog limit in cycles (used only when the optional feature is compiled in)

Ports:
ACLK  in  1  clock
ARESET  in  1  reset; asynchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accept
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transaction address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_err  out  1  transaction timed out
AWADDR  out  ADDR_W
AWVALID  out  1
AWREADY  in  1
WDATA  out  DATA_W
WSTRB  out  DATA_W/8
WVALID  out  1
WREADY  in  1
BVALID  in  1
BREADY  out  1
ARADDR  out  ADDR_W
ARVALID  out  1
ARREADY  in  1
RDATA  in  DATA_W
RVALID  in  1
RREADY  out  1

Behaviour:
- Reset (ARESET=1, asynchronous):
  - All outputs are 0: VALIDs, READYs, addresses, data, strobes, rsp_* and cmd_ready.
  - State goes to IDLE and the internal done flags clear.
  - If reset asserts mid-transaction, the transaction is abandoned immediately and no response is produced.
- cmd_ready = 1 only in IDLE. It is a registered output and drops in the cycle after acceptance.
- States and transitions:
  - IDLE: on cmd_valid && cmd_ready, latch cmd_*. Write goes to WR_REQ; read goes to RD_ADDR.
  - WR_REQ:
    - AWVALID and WVALID both rise in the cycle after acceptance.
    - Each VALID falls independently after its own handshake (VALID && READY at a clock edge). Flags aw_done and w_done record completion.
    - AW and W may complete in the same cycle or in any order. A VALID, once raised, stays high with address and data stable until its handshake.
    - When both flags are set, go to WR_RESP.
  - WR_RESP: BREADY = 1. On BVALID && BREADY, drop BREADY and go to RSP with rsp_write=1, rsp_rdata=0.
  - RD_ADDR: ARVALID = 1 and held stable until ARREADY. Then drop ARVALID and go to RD_DATA.
  - RD_DATA: RREADY = 1. On RVALID && RREADY, capture RDATA into rsp_rdata, drop RREADY, and go to RSP with rsp_write=0.
  - RSP: rsp_valid = 1, with rsp_* held stable until rsp_ready. Then go to IDLE, where cmd_ready returns to 1 in the next cycle.
- Ready/valid dependencies: BREADY and RREADY are never asserted before their request phase completes. No VALID depends combinationally on any READY.
- Minimum latency: command accept to rsp_valid is 4 cycles for a write and 4 cycles for a read, with zero-wait responders.
- Ignored inputs: BVALID or RVALID arriving outside WR_RESP/RD_DATA is ignored and does not change state. cmd_valid outside IDLE is ignored.

Optional Feature:
- Macro: AXIL_MST_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WR_REQ, WR_RESP, RD_ADDR or RD_DATA and increments each cycle in those states.
  - At TIMEOUT_CYCLES it deasserts all VALIDs and READYs and goes to RSP with rsp_err=1, rsp_rdata=0, and rsp_write set to the command type.
  - A handshake that lands in the same cycle as expiry wins: normal completion, no error.
- Not defined: no counter; the bridge waits indefinitely; rsp_err is constant 0.

Test Plan:
- Write addr=0x0000_0010, data=0xDEAD_BEEF, wstrb=0xF; responder raises AWREADY and WREADY in the same cycle with BVALID one cycle later -> one AW and one W handshake with exact values, then BREADY; rsp_valid 4 cycles after accept, rsp_write=1, rsp_err=0.
- Write with AWREADY at cycle+1 and WREADY at cycle+4 -> AWVALID drops after cycle+1 while WVALID stays high with WDATA stable; BREADY is not asserted until after the W handshake.
- Read addr=0x0000_0020; ARREADY delayed 2 cycles, RVALID delayed 3 cycles, RDATA=0x1234_5678 -> rsp_rdata=0x1234_5678, rsp_write=0; RREADY high only in RD_DATA.
- rsp_ready held low for 5 cycles after rsp_valid -> rsp_* stable all 5 cycles, cmd_ready=0 throughout, next command accepted only after the rsp handshake.
- ARESET pulsed while WVALID is pending -> all outputs 0 asynchronously, no rsp_valid; a fresh read after reset completes normally.
- With AXIL_MST_TIMEOUT_EN and TIMEOUT_CYCLES=16, a read where ARREADY never rises -> ARVALID drops after 16 cycles, rsp_valid with rsp_err=1, rsp_rdata=0.
